// File: rtl/fp32_to_int32_pkg.sv
// Shared FP32/INT32 constants and the converter state encoding.
package fp_pkg;

  localparam int FP32_BIAS   = 127;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_MANT_W = 23;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  // Exponent field values bounding the shift path (e = -1 .. 30), and the
  // exponent at which the binary point sits right below mag[0] (e = 23).
  localparam logic [7:0] EXP_SHIFT_LO = 8'(FP32_BIAS - 1);
  localparam logic [7:0] EXP_SAT      = 8'(FP32_BIAS + 31);
  localparam logic [7:0] EXP_UNITY    = 8'(FP32_BIAS + FP32_MANT_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/fp32_to_int32_if.sv
// Valid/ready operand and result channels of the FP32 -> INT32 converter.
interface fp32_to_int32_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_fp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_int;
  logic        out_ovf;

  modport master (
    output in_valid, in_fp, out_ready,
    input  in_ready, out_valid, out_int, out_ovf
  );

  modport slave (
    input  in_valid, in_fp, out_ready,
    output in_ready, out_valid, out_int, out_ovf
  );
endinterface

// File: rtl/fp32_to_int32_align_shifter.sv
// Combinational alignment step: shifts the magnitude by k bits (k <= 8).
// Right shifts feed the top dropped bit into guard and fold everything else
// that falls off (including the old guard) into sticky.
module fp_align_shifter (
  input  logic [31:0] mag_i,
  input  logic        guard_i,
  input  logic        sticky_i,
  input  logic        dir_i,     // 1 = left, 0 = right
  input  logic [3:0]  k_i,
  output logic [31:0] mag_o,
  output logic        guard_o,
  output logic        sticky_o
);

  logic [64:0] ext_r;

  // Select left or right alignment of {mag, guard, sticky}
  always_comb begin
    ext_r = {mag_i, guard_i, 32'd0} >> k_i;
    if (dir_i) begin
      mag_o    = mag_i << k_i;
      guard_o  = guard_i;
      sticky_o = sticky_i;
    end else begin
      mag_o    = ext_r[64:33];
      guard_o  = ext_r[32];
      sticky_o = sticky_i | (|ext_r[31:0]);
    end
  end

endmodule

// File: rtl/fp32_to_int32.sv
// Multi-cycle FP32 -> signed INT32 converter with an iterative aligner.
// Optional feature macro FP2INT_ROUND_EN: round-to-nearest-even instead of
// truncation toward zero.
//
// state  | meaning
// IDLE   | in_ready high, waiting for an operand
// SHIFT  | aligning mag by up to SHIFT_STEP bits per cycle until cnt == 0
// FINISH | round, apply sign, register the result
// DONE   | result held on out_* until out_ready
module fp32_to_int32 #(
  parameter int SHIFT_STEP = 1
) (
  input logic            clk,
  input logic            reset,
  fp32_to_int32_if.slave bus
);
  import fp_pkg::*;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t      state_q;
  logic        sign_q, dir_q, guard_q, sticky_q, ovf_q;
  logic [31:0] mag_q;
  logic [4:0]  cnt_q;
  logic        out_valid_q, out_ovf_q;
  logic [31:0] out_int_q;

  logic [7:0]  exp_w;
  logic        dir_w;
  logic [4:0]  cnt_w;
  logic [3:0]  k_w;
  logic [31:0] sh_mag_w;
  logic        sh_guard_w, sh_sticky_w;
  logic        round_inc_w;
  logic [31:0] mag_rnd_w, res_w;

  assign exp_w = bus.in_fp[30:23];
  assign dir_w = exp_w > EXP_UNITY;
  assign cnt_w = dir_w ? 5'(exp_w - EXP_UNITY) : 5'(EXP_UNITY - exp_w);
  assign k_w   = (cnt_q < STEP) ? cnt_q[3:0] : STEP[3:0];

  fp_align_shifter u_shift (
    .mag_i    (mag_q),
    .guard_i  (guard_q),
    .sticky_i (sticky_q),
    .dir_i    (dir_q),
    .k_i      (k_w),
    .mag_o    (sh_mag_w),
    .guard_o  (sh_guard_w),
    .sticky_o (sh_sticky_w)
  );

`ifdef FP2INT_ROUND_EN
  assign round_inc_w = guard_q & (sticky_q | mag_q[0]);
`else
  assign round_inc_w = 1'b0;
`endif

  // Saturated and zero paths park their final magnitude in mag_q with
  // guard = 0, so FINISH treats every path the same way.
  assign mag_rnd_w = mag_q + {31'd0, round_inc_w};
  assign res_w     = sign_q ? (~mag_rnd_w + 32'd1) : mag_rnd_w;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_int   = out_int_q;
  assign bus.out_ovf   = out_ovf_q;

  // Converter FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      dir_q       <= 1'b0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      ovf_q       <= 1'b0;
      mag_q       <= 32'd0;
      cnt_q       <= 5'd0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_int_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sign_q   <= bus.in_fp[31];
            dir_q    <= dir_w;
            cnt_q    <= cnt_w;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
            if (exp_w < EXP_SHIFT_LO) begin
              mag_q   <= 32'd0;
              state_q <= FINISH;
            end else if (exp_w >= EXP_SAT) begin
              // -2^31 is the only out-of-range-exponent value INT32 can hold
              mag_q   <= bus.in_fp[31] ? INT32_MIN : INT32_MAX;
              ovf_q   <= bus.in_fp[31] ? (bus.in_fp != 32'hCF00_0000) : 1'b1;
              state_q <= FINISH;
            end else begin
              mag_q   <= {8'd0, 1'b1, bus.in_fp[22:0]};
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (cnt_q == 5'd0) begin
            state_q <= FINISH;
          end else begin
            mag_q    <= sh_mag_w;
            guard_q  <= sh_guard_w;
            sticky_q <= sh_sticky_w;
            cnt_q    <= cnt_q - {1'b0, k_w};
          end
        end
        FINISH: begin
          out_int_q   <= res_w;
          out_ovf_q   <= ovf_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_to_int32.sv
// Randomized and directed bench for fp32_to_int32 against a value-level model.
module tb_fp32_to_int32;

  localparam int STEP = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp32_to_int32_if bus();

  fp32_to_int32 #(.SHIFT_STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] r;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   front_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Value-level model: integer part of the real value, then rounding from the remainder
  function automatic void model(input logic [31:0] fp, output logic [31:0] r,
                                output logic ovf, output int lat);
    int     ex;
    int     e;
    int     sh;
    longint mag;
    longint iv;
    longint rem;
    longint half;
    ex  = int'(fp[30:23]);
    e   = ex - 127;
    mag = longint'({1'b1, fp[22:0]});
    ovf = 1'b0;
    if (ex == 0 || e < -1) begin
      r   = 32'd0;
      lat = 1;
    end else if (e >= 31) begin
      lat = 1;
      if (!fp[31]) begin
        r   = 32'h7FFF_FFFF;
        ovf = 1'b1;
      end else begin
        r   = 32'h8000_0000;
        ovf = (fp != 32'hCF00_0000);
      end
    end else begin
      if (e >= 23) begin
        iv  = mag << (e - 23);
        lat = (e - 23 + STEP - 1) / STEP + 2;
      end else begin
        sh   = 23 - e;
        iv   = mag >> sh;
        rem  = mag - (iv << sh);
        half = 64'd1 << (sh - 1);
`ifdef FP2INT_ROUND_EN
        if (rem > half || (rem == half && iv[0])) iv = iv + 1;
`endif
        lat = (sh + STEP - 1) / STEP + 2;
      end
      r = 32'(fp[31] ? -iv : iv);
    end
  endfunction

  // Compare process: every cycle a result is presented
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid: got out_int=%h with no pending operand", bus.out_int);
      end else begin
        if (!front_seen) begin
          chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
          front_seen = 1;
        end
        chk("out_int", bus.out_int, q[0].r);
        chk("out_ovf", {31'd0, bus.out_ovf}, {31'd0, q[0].ovf});
        chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
        if (bus.out_ready) begin
          void'(q.pop_front());
          front_seen = 0;
        end
      end
    end
  end

  task automatic convert(input logic [31:0] fp, input int hold);
    int          n;
    logic [31:0] r;
    logic        o;
    int          l;
    logic [31:0] first;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    model(fp, r, o, l);
    bus.in_fp    = fp;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_fp    = $urandom;
    q.push_back('{r: r, ovf: o, lat: l, acc: cyc});
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("out_valid_wait", {31'd0, bus.out_valid}, 32'd1);
    if (!bus.out_valid) begin
      q.delete();
      front_seen = 0;
      return;
    end
    first = bus.out_int;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", bus.out_int, first);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, bus.out_valid}, 32'd0);
  endtask

  // Pin the model to hand-computed values, then run the operand through the DUT
  task automatic pin(input logic [31:0] fp, input logic [31:0] v_rnd,
                     input logic [31:0] v_trunc, input logic ovf_req, input int hold);
    logic [31:0] r;
    logic        o;
    int          l;
    model(fp, r, o, l);
`ifdef FP2INT_ROUND_EN
    chk("model_value", r, v_rnd);
`else
    chk("model_value", r, v_trunc);
`endif
    chk("model_ovf", {31'd0, o}, {31'd0, ovf_req});
    convert(fp, hold);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] fp;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_fp     = 32'd0;
    bus.out_ready = 1'b0;
    #1;
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_out_int", bus.out_int, 32'd0);
    chk("reset_out_ovf", {31'd0, bus.out_ovf}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    pin(32'h40A0_0000, 32'd5, 32'd5, 1'b0, 0);
    pin(32'h402C_CCCD, 32'd3, 32'd2, 1'b0, 1);
    pin(32'h4020_0000, 32'd2, 32'd2, 1'b0, 0);
    pin(32'h4060_0000, 32'd4, 32'd3, 1'b0, 2);
    pin(32'hC060_0000, -32'sd4, -32'sd3, 1'b0, 0);
    pin(32'h3F40_0000, 32'd1, 32'd0, 1'b0, 0);
    pin(32'h4F00_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 0);
    pin(32'hCF00_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    pin(32'hCF00_0001, 32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    pin(32'h4EFF_FFFF, 32'h7FFF_FF80, 32'h7FFF_FF80, 1'b0, 0);
    pin(32'h0000_0000, 32'd0, 32'd0, 1'b0, 0);
    pin(32'h8000_0000, 32'd0, 32'd0, 1'b0, 0);
    pin(32'h3E80_0000, 32'd0, 32'd0, 1'b0, 0);
    pin(32'h7F80_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 0);
    pin(32'h4000_0000, 32'd2, 32'd2, 1'b0, 10);
    pin(32'hC120_0000, -32'sd10, -32'sd10, 1'b0, 0);

    // Abort a conversion in SHIFT: outputs clear at once, nothing is emitted
    bus.in_fp    = 32'h4B00_0000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_out_int", bus.out_int, 32'd0);
    chk("abort_out_ovf", {31'd0, bus.out_ovf}, 32'd0);
    chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_result", {31'd0, bus.out_valid}, 32'd0);
    end
    pin(32'h3F80_0000, 32'd1, 32'd1, 1'b0, 0);

    for (int i = 0; i < 300; i++) begin
      fp[31]    = 1'($urandom_range(0, 1));
      fp[30:23] = 8'($urandom_range(118, 162));
      fp[22:0]  = 23'($urandom);
      if ($urandom_range(0, 15) == 0) fp[30:23] = 8'd0;
      if ($urandom_range(0, 15) == 0) fp[30:23] = 8'd255;
      convert(fp, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
